// File: rtl/axi_pim_pkg.sv
// Shared types and constants for the axi_pim job sequencer.
package axi_pim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Beat counter is one bit wider than len so len=255 cannot wrap.
    function automatic logic is_last_beat(input logic [8:0] count, input logic [7:0] len);
        return count == {1'b0, len};
    endfunction

endpackage

// File: rtl/axi_pim_seq_if.sv
// AXI4 master-side signal bundle used between axi_pim_seq and the axi_pim slave.
// ID, size, burst, strobe, lock, cache and prot are tied off at integration.
interface axi_pim_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awvalid, output awready,
        input wdata, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_pim_seq.sv
// AXI4 job sequencer for axi_pim: one INCR write burst of operands, wait for
// the write response, read the result burst back from the same base, and
// forward it on the output stream. One job in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a job
// AW      | write address presented until accepted
// W       | operand stream passed straight through to the W channel
// B       | waiting for the write response (error noted, never blocks)
// AR      | read address presented until accepted
// R       | R channel passed straight through to the result stream
// DONE    | one-cycle done pulse with err
module axi_pim_seq
    import axi_pim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  done_o,
    output logic                  err_o,
    axi_pim_seq_if.master         m_axi
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            count_q, count_d;
    logic                  err_q, err_d;

    logic                  cmd_ready_c;
    logic                  awvalid_c;
    logic                  wvalid_c;
    logic                  wlast_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  bready_c;
    logic                  arvalid_c;
    logic                  rready_c;
    logic                  last_beat;

    assign last_beat = is_last_beat(count_q, len_q);

    // State and job registers; reset aborts any job and drops all valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state and channel control; the W and R phases are pure pass-throughs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        count_d     = count_q;
        err_d       = err_q;
        cmd_ready_c = 1'b0;
        awvalid_c   = 1'b0;
        wvalid_c    = 1'b0;
        wlast_c     = 1'b0;
        wdata_c     = '0;
        s_ready_o   = 1'b0;
        bready_c    = 1'b0;
        arvalid_c   = 1'b0;
        rready_c    = 1'b0;
        m_valid_o   = 1'b0;
        m_data_o    = '0;
        done_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    err_d   = 1'b0;
                    count_d = '0;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                awvalid_c = 1'b1;
                if (m_axi.awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                s_ready_o = m_axi.wready;
                wvalid_c  = s_valid_i;
                wdata_c   = s_data_i;
                wlast_c   = last_beat;
                if (s_valid_i && m_axi.wready) begin
                    count_d = count_q + 9'd1;
                    if (last_beat) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                bready_c = 1'b1;
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                arvalid_c = 1'b1;
                if (m_axi.arready) begin
                    count_d = '0;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                m_valid_o = m_axi.rvalid;
                m_data_o  = m_axi.rdata;
                rready_c  = m_ready_i;
                if (m_axi.rvalid && m_ready_i) begin
                    count_d = count_q + 9'd1;
                    if (m_axi.rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // Early rlast or a missing rlast both end the burst as an error.
                    if (m_axi.rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (m_axi.rlast || last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // IDLE is the reset state, so hold cmd_ready low while rst is asserted.
    assign cmd_ready_o   = cmd_ready_c & ~rst;
    assign err_o         = err_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awvalid = awvalid_c;
    assign m_axi.wdata   = wdata_c;
    assign m_axi.wlast   = wlast_c;
    assign m_axi.wvalid  = wvalid_c;
    assign m_axi.bready  = bready_c;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arvalid = arvalid_c;
    assign m_axi.rready  = rready_c;

endmodule

// File: tb/tb_axi_pim_seq.sv
// Randomized bench for axi_pim_seq: memory-backed AXI slave, operand source,
// result sink, and a job-level reference model checked every cycle.
module tb_axi_pim_seq;
    import axi_pim_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axi_pim_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi_pim_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .done_o      (done),
        .err_o       (err),
        .m_axi       (axi)
    );

    // Job description, written only by the main stimulus process.
    int            job_seq = 0;
    logic [AW-1:0] job_addr = '0;
    int            job_len = 0;
    logic [31:0]   job_ops [0:15];
    int            exp_n = 0;
    bit            exp_err = 1'b0;
    int            lit_sel = 0;
    logic [1:0]    cfg_bresp = RESP_OKAY;
    int            cfg_early = -1;
    int            cfg_rresp_beat = -1;
    int            src_mode = 0;
    int            snk_mode = 0;

    // Monitor state, written only by the monitor process.
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          in_flight = 1'b0;
    int          w_idx = 0;
    int          out_idx = 0;
    int          done_cnt = 0;
    bit          aw_seen = 1'b0;
    bit          ar_seen = 1'b0;
    int          last_r_cyc = 0;
    logic [31:0] got [0:15];
    logic [7:0]  got_awlen = '0;
    logic        first_wlast = 1'b0;

    logic [31:0] mem [0:63];

    function automatic int widx(input logic [7:0] a, input int i);
        return (int'(a >> 2) + i) & 63;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the job model on every cycle.
    initial begin
        bit            p_awv, p_awr, p_arv, p_arr;
        logic [AW-1:0] p_awa, p_ara;
        logic [7:0]    p_awl, p_arl;
        p_awv = 0; p_awr = 0; p_arv = 0; p_arr = 0;
        p_awa = '0; p_ara = '0; p_awl = '0; p_arl = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("reset_ctrl", {cmd_ready, s_ready, m_valid, done, err, axi.awvalid, axi.wvalid,
                                   axi.wlast, axi.bready, axi.arvalid, axi.rready}, 0);
                chk("reset_data", m_data | axi.wdata, 0);
                chk("reset_addr", {axi.awaddr, axi.awlen, axi.araddr, axi.arlen}, 0);
                in_flight = 0;
                p_awv = 0; p_arv = 0;
                continue;
            end
            chk("cmd_ready", cmd_ready, !in_flight);
            if (!in_flight)
                chk("idle_quiet", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                                   m_valid, s_ready, done}, 0);
            if (p_awv && !p_awr)
                chk("aw_hold", {axi.awvalid, axi.awaddr, axi.awlen}, {1'b1, p_awa, p_awl});
            if (p_arv && !p_arr)
                chk("ar_hold", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, p_ara, p_arl});
            if (axi.awvalid && axi.awready) begin
                chk("aw_once", aw_seen, 0);
                chk("aw_addr", axi.awaddr, job_addr);
                chk("aw_len", axi.awlen, job_len);
                aw_seen = 1;
                got_awlen = axi.awlen;
            end
            if (axi.wvalid)
                chk("w_passthru", {s_ready, axi.wdata}, {axi.wready, s_data});
            if (axi.wvalid && axi.wready) begin
                chk("w_after_aw", aw_seen, 1);
                if (w_idx <= job_len) begin
                    chk("w_data", axi.wdata, job_ops[w_idx]);
                    chk("w_last", axi.wlast, w_idx == job_len);
                    if (w_idx == 0) first_wlast = axi.wlast;
                end else begin
                    chk("w_extra_beat", w_idx, job_len);
                end
                w_idx++;
            end
            if (axi.arvalid && axi.arready) begin
                chk("ar_once", ar_seen, 0);
                chk("ar_after_w", w_idx, job_len + 1);
                chk("ar_addr", axi.araddr, job_addr);
                chk("ar_len", axi.arlen, job_len);
                ar_seen = 1;
            end
            if (m_valid)
                chk("r_passthru", {axi.rready, m_data}, {m_ready, axi.rdata});
            if (m_valid && m_ready) begin
                chk("r_after_ar", ar_seen, 1);
                if (out_idx < exp_n) begin
                    chk("m_data", m_data, job_ops[out_idx]);
                    got[out_idx] = m_data;
                end else begin
                    chk("m_extra_beat", out_idx, exp_n);
                end
                out_idx++;
                last_r_cyc = cyc;
            end
            if (done) begin
                chk("done_in_job", in_flight, 1);
                if (in_flight) begin
                    chk("err_at_done", err, exp_err);
                    chk("out_beats", out_idx, exp_n);
                    chk("w_beats", w_idx, job_len + 1);
                    chk("aw_ar_seen", {aw_seen, ar_seen}, 2'b11);
                    chk("done_latency", cyc - last_r_cyc, 1);
                    case (lit_sel)
                        1: begin
                            chk("lit_first", got[0], 32'hDEADBEEF);
                            chk("lit_last", got[3], 32'hDEADBEF2);
                            chk("lit_count", out_idx, 4);
                            chk("lit_err0", err, 0);
                        end
                        2: begin
                            chk("lit_len0_data", got[0], 32'h12345678);
                            chk("lit_len0_awlen", got_awlen, 0);
                            chk("lit_len0_wlast", first_wlast, 1);
                            chk("lit_len0_count", out_idx, 1);
                        end
                        3: begin
                            chk("lit_bresp_err", err, 1);
                            chk("lit_bresp_count", out_idx, 4);
                        end
                        4: begin
                            chk("lit_early_err", err, 1);
                            chk("lit_early_count", out_idx, 2);
                        end
                        default: ;
                    endcase
                end
                done_cnt++;
                in_flight = 0;
            end
            if (cmd_valid && cmd_ready) begin
                in_flight = 1;
                w_idx = 0;
                out_idx = 0;
                aw_seen = 0;
                ar_seen = 0;
            end
            p_awv = axi.awvalid; p_awr = axi.awready; p_awa = axi.awaddr; p_awl = axi.awlen;
            p_arv = axi.arvalid; p_arr = axi.arready; p_ara = axi.araddr; p_arl = axi.arlen;
        end
    end

    // Memory-backed AXI slave: stores written beats, returns them on read.
    initial begin
        bit            aw_f, w_f, b_f, ar_f, r_f, r_l, b_pend, r_act;
        logic [AW-1:0] aw_a, ar_a, sl_awaddr, sl_araddr;
        int            aw_l, ar_l, sl_awlen, sl_arlen, wbeat, rbeat;
        logic [31:0]   wd;
        b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0;
        sl_awaddr = '0; sl_araddr = '0; sl_awlen = 0; sl_arlen = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.arready = 0;
        axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        forever begin
            @(negedge clk);
            aw_f = axi.awvalid && axi.awready; aw_a = axi.awaddr; aw_l = int'(axi.awlen);
            w_f  = axi.wvalid && axi.wready;   wd = axi.wdata;
            b_f  = axi.bvalid && axi.bready;
            ar_f = axi.arvalid && axi.arready; ar_a = axi.araddr; ar_l = int'(axi.arlen);
            r_f  = axi.rvalid && axi.rready;   r_l = axi.rlast;
            @(posedge clk);
            #1;
            if (rst) begin
                b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.arready = 0;
                axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
                continue;
            end
            if (aw_f) begin sl_awaddr = aw_a; sl_awlen = aw_l; wbeat = 0; end
            if (w_f) begin
                mem[widx(sl_awaddr, wbeat)] = wd;
                if (wbeat == sl_awlen) b_pend = 1;
                wbeat++;
            end
            if (b_f) axi.bvalid = 0;
            if (b_pend && !axi.bvalid) begin
                axi.bvalid = 1;
                axi.bresp = cfg_bresp;
                b_pend = 0;
            end
            if (ar_f) begin sl_araddr = ar_a; sl_arlen = ar_l; rbeat = 0; r_act = 1; end
            if (r_f) begin
                rbeat++;
                if (r_l) r_act = 0;
            end
            if (!axi.rvalid || r_f) begin
                if (r_act && ($urandom % 4 != 0)) begin
                    axi.rvalid = 1;
                    axi.rdata  = mem[widx(sl_araddr, rbeat)];
                    axi.rlast  = (rbeat == sl_arlen) || (rbeat == cfg_early);
                    axi.rresp  = (rbeat == cfg_rresp_beat) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    axi.rvalid = 0; axi.rlast = 0; axi.rdata = 0; axi.rresp = RESP_OKAY;
                end
            end
            axi.awready = ($urandom % 2) == 1;
            axi.wready  = ($urandom % 3) != 0;
            axi.arready = ($urandom % 2) == 1;
        end
    end

    // Operand source: presents the job's operands in order, holding valid until accepted.
    initial begin
        int my_seq, idx, tc;
        bit fire, go;
        my_seq = 0; idx = 999; tc = 0;
        s_valid = 0; s_data = '0;
        forever begin
            @(negedge clk);
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            tc++;
            if (rst) begin
                s_valid = 0;
                idx = 999;
                continue;
            end
            if (job_seq != my_seq) begin
                my_seq = job_seq;
                idx = 0;
            end else if (fire) begin
                idx++;
            end
            if (!(s_valid && !fire)) begin
                go = (src_mode == 0) || (src_mode == 1 && tc % 2 == 0) ||
                     (src_mode == 2 && $urandom % 2 == 1);
                if (idx <= job_len && go) begin
                    s_valid = 1;
                    s_data = job_ops[idx];
                end else begin
                    s_valid = 0;
                end
            end
        end
    end

    // Result sink: ready pattern chosen per job.
    initial begin
        m_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) m_ready = 0;
            else if (snk_mode == 0) m_ready = 1;
            else if (snk_mode == 1) m_ready = ~m_ready;
            else m_ready = ($urandom % 2) == 1;
        end
    end

    task automatic start_job(input logic [7:0] addr, input int len, input logic [1:0] bresp,
                             input int early, input int rbeat, input int sm, input int km,
                             input int lit, input bit seq_ops, input logic [31:0] base,
                             output int d0);
        int last;
        for (int i = 0; i < 500 && in_flight; i++) @(negedge clk);
        if (in_flight) begin
            $display("FAIL idle_timeout: job still in flight after 500 cycles");
            $fatal(1);
        end
        @(posedge clk);
        #2;
        job_addr = addr;
        job_len = len;
        for (int i = 0; i <= len; i++) job_ops[i] = seq_ops ? base + 32'(i) : $urandom;
        cfg_bresp = bresp;
        cfg_early = early;
        cfg_rresp_beat = rbeat;
        last = (early >= 0 && early < len) ? early : len;
        exp_n = last + 1;
        exp_err = (bresp != RESP_OKAY) || (early >= 0 && early < len) ||
                  (rbeat >= 0 && rbeat <= last);
        lit_sel = lit;
        src_mode = sm;
        snk_mode = km;
        job_seq++;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_addr = addr;
        cmd_len = 8'(len);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == d0) begin
            $display("FAIL done_timeout: no done within 4000 cycles, done count %0d", done_cnt);
            $fatal(1);
        end
    endtask

    initial begin
        int d0;
        logic [7:0] a;
        int len, early, rb, sm, km;
        logic [1:0] br;
        $display("tb_axi_pim_seq start (INCR burst code %0d tied off)", BURST_INCR);
        rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #3 rst = 0;

        start_job(8'h00, 3, RESP_OKAY, -1, -1, 0, 0, 1, 1, 32'hDEADBEEF, d0);
        wait_done(d0);
        start_job(8'h00, 3, RESP_OKAY, -1, -1, 1, 1, 1, 1, 32'hDEADBEEF, d0);
        wait_done(d0);
        start_job(8'h20, 0, RESP_OKAY, -1, -1, 0, 0, 2, 1, 32'h12345678, d0);
        wait_done(d0);
        start_job(8'h08, 3, RESP_SLVERR, -1, -1, 2, 2, 3, 0, 32'h0, d0);
        wait_done(d0);
        start_job(8'h30, 3, RESP_OKAY, 1, -1, 0, 0, 4, 0, 32'h0, d0);
        wait_done(d0);

        // Abort during W beat 2, then a clean job.
        start_job(8'h40, 3, RESP_OKAY, -1, -1, 0, 0, 0, 0, 32'h0, d0);
        for (int i = 0; i < 500 && w_idx < 2; i++) begin
            @(negedge clk);
            #1;
        end
        if (w_idx < 2) begin
            $display("FAIL w_beat_timeout: reached beat %0d, need 2", w_idx);
            $fatal(1);
        end
        @(posedge clk);
        #3 rst = 1;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        start_job(8'h44, 5, RESP_OKAY, -1, -1, 2, 2, 0, 0, 32'h0, d0);
        wait_done(d0);

        // Commands offered while busy must be ignored.
        start_job(8'h10, 7, RESP_OKAY, -1, -1, 1, 1, 0, 0, 32'h0, d0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1;
            cmd_addr = 8'hA0;
            cmd_len = 8'd1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
        wait_done(d0);
        repeat (30) @(negedge clk);

        for (int j = 0; j < 20; j++) begin
            len = int'($urandom_range(0, 15));
            a = 8'($urandom_range(0, 63)) << 2;
            br = ($urandom % 4 == 0) ? RESP_SLVERR : RESP_OKAY;
            early = -1;
            if (len > 0 && $urandom % 4 == 0) early = int'($urandom_range(0, len - 1));
            rb = -1;
            if ($urandom % 5 == 0) rb = int'($urandom_range(0, len));
            sm = int'($urandom_range(0, 2));
            km = int'($urandom_range(0, 2));
            start_job(a, len, br, early, rb, sm, km, 0, 0, 32'h0, d0);
            wait_done(d0);
        end

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
